multicycle_ctrl: RTL and testbench

//  Main control FSM of the multicycle RV32I core. Sequences one shared ALU, one shared memory port,
//  the register file and the PC/IR/ALUOut/MDR registers through FETCH..WRITEBACK per instruction.

---
 rtl/multicycle_ctrl.sv | 271 +++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Main control FSM of the multicycle RV32I core. One instruction walks through
//   FETCH -> DECODE -> (execute / memory states) -> write-back, sharing a single
//   ALU and a single memory port. Memory accesses use a req/ready handshake:
//   mem_req is held in FETCH/MEMRD/MEMWR until mem_ready is seen.
//
// Parameters
//   ST_W       width of state_dbg
//   RESET_PC   constant presented on pc_init (PC register loads it in reset)
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   opcode/funct3/funct7b5 instruction fields from IR
//   br_taken               branch comparator result, used in BRANCH
//   mem_ready              memory completes the current access this cycle
//   mem_req/mem_we/adr_src memory request, store qualifier, address select
//   ir_write/pc_write      IR/oldPC load, PC load
//   reg_write              register file write enable
//   alu_src_a/alu_src_b    ALU operand selects
//   alu_op                 00 add, 01 sub, 10 decode funct fields
//   result_src             00 ALUOut, 01 MDR, 10 ALU result
//   pc_init                RESET_PC
//   illegal                sticky unsupported-opcode flag
//   state_dbg              current state encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int          ST_W     = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            br_taken,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            adr_src,
    output logic            ir_write,
    output logic            pc_write,
    output logic            reg_write,
    output logic [1:0]      alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      result_src,
    output logic [31:0]     pc_init,
    output logic            illegal,
    output logic [ST_W-1:0] state_dbg
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_JAL    = 4'd10;
    localparam logic [3:0] S_JALR   = 4'd11;
    localparam logic [3:0] S_LUI    = 4'd12;
    localparam logic [3:0] S_AUIPC  = 4'd13;
    localparam logic [3:0] S_JALWB  = 4'd14;
    localparam logic [3:0] S_HALT   = 4'd15;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic [3:0] state_r;
    logic [3:0] next_s;
    logic       illegal_r;

    logic       mem_req_s;
    logic       mem_we_s;
    logic       adr_src_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       reg_write_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [1:0] alu_op_s;
    logic [1:0] result_src_s;

    // funct3/funct7b5 are consumed by the ALU decoder, not by this FSM
    logic       unused_fields_s;
    assign unused_fields_s = ^{funct3, funct7b5};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Sticky illegal flag: any entry into HALT (bad opcode or corrupted state) sets it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (next_s == S_HALT) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_FETCH:  next_s = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_s = S_MEMADR;
                    OP_REG:            next_s = S_EXECR;
                    OP_IMM:            next_s = S_EXECI;
                    OP_BRANCH:         next_s = S_BRANCH;
                    OP_JAL:            next_s = S_JAL;
                    OP_JALR:           next_s = S_JALR;
                    OP_LUI:            next_s = S_LUI;
                    OP_AUIPC:          next_s = S_AUIPC;
                    default:           next_s = S_HALT;
                endcase
            end
            S_MEMADR: next_s = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next_s = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  next_s = S_FETCH;
            S_MEMWR:  next_s = mem_ready ? S_FETCH : S_MEMWR;
            S_EXECR:  next_s = S_ALUWB;
            S_EXECI:  next_s = S_ALUWB;
            S_ALUWB:  next_s = S_FETCH;
            S_BRANCH: next_s = S_FETCH;
            // JAL writes rd from ALUOut (oldPC+4 computed here) in ALUWB
            S_JAL:    next_s = S_ALUWB;
            S_JALR:   next_s = S_JALWB;
            S_LUI:    next_s = S_ALUWB;
            S_AUIPC:  next_s = S_ALUWB;
            S_JALWB:  next_s = S_FETCH;
            S_HALT:   next_s = S_HALT;
            default:  next_s = S_HALT;
        endcase
    end

    // Output decode; everything is forced to idle while rst_n is low so an
    // in-flight memory request drops without waiting for a clock edge
    always_comb begin
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        adr_src_s    = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = 2'b00;
        alu_src_b_s  = 2'b00;
        alu_op_s     = 2'b00;
        result_src_s = 2'b00;
        if (rst_n) begin
            case (state_r)
                S_FETCH: begin
                    mem_req_s = 1'b1;
                    if (mem_ready) begin
                        ir_write_s   = 1'b1;
                        pc_write_s   = 1'b1;
                        alu_src_b_s  = 2'b10;
                        result_src_s = 2'b10;
                    end else begin
                        ir_write_s   = 1'b0;
                    end
                end
                S_DECODE: begin
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a_s = 2'b10;
                    alu_src_b_s = 2'b01;
                end
                S_MEMRD: begin
                    mem_req_s = 1'b1;
                    adr_src_s = 1'b1;
                end
                S_MEMWB: begin
                    result_src_s = 2'b01;
                    reg_write_s  = 1'b1;
                end
                S_MEMWR: begin
                    mem_req_s = 1'b1;
                    mem_we_s  = 1'b1;
                    adr_src_s = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a_s = 2'b10;
                    alu_op_s    = 2'b10;
                end
                S_EXECI: begin
                    alu_src_a_s = 2'b10;
                    alu_src_b_s = 2'b01;
                    alu_op_s    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write_s = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_s = 2'b10;
                    alu_op_s    = 2'b01;
                    pc_write_s  = br_taken;
                end
                S_JAL: begin
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b10;
                    pc_write_s  = 1'b1;
                end
                S_JALR: begin
                    alu_src_a_s  = 2'b10;
                    alu_src_b_s  = 2'b01;
                    result_src_s = 2'b10;
                    pc_write_s   = 1'b1;
                end
                S_JALWB: begin
                    alu_src_a_s  = 2'b01;
                    alu_src_b_s  = 2'b10;
                    result_src_s = 2'b10;
                    reg_write_s  = 1'b1;
                end
                S_LUI: begin
                    alu_src_a_s = 2'b11;
                    alu_src_b_s = 2'b01;
                end
                S_AUIPC: begin
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b01;
                end
                S_HALT: begin
                    mem_req_s = 1'b0;
                end
                default: begin
                    mem_req_s = 1'b0;
                end
            endcase
        end else begin
            mem_req_s = 1'b0;
        end
    end

    assign mem_req    = mem_req_s;
    assign mem_we     = mem_we_s;
    assign adr_src    = adr_src_s;
    assign ir_write   = ir_write_s;
    assign pc_write   = pc_write_s;
    assign reg_write  = reg_write_s;
    assign alu_src_a  = alu_src_a_s;
    assign alu_src_b  = alu_src_b_s;
    assign alu_op     = alu_op_s;
    assign result_src = result_src_s;
    assign pc_init    = RESET_PC;
    assign illegal    = illegal_r;
    assign state_dbg  = ST_W'(state_r);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Instruction-level scenarios for the multicycle control FSM. For every cycle
//   the expected output vector is pushed to a scoreboard queue as the inputs
//   are applied and popped/compared when the DUT outputs are sampled at the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        br_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  result_src;
    logic [31:0] pc_init;
    logic        illegal;
    logic [3:0]  state_dbg;

    int          tests_run;
    int          tests_failed;
    logic [18:0] sb_q[$];

    multicycle_ctrl #(.ST_W(4), .RESET_PC(32'h0000_1000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .br_taken   (br_taken),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .result_src (result_src),
        .pc_init    (pc_init),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected output vector: state, req, we, adr, irw, pcw, rw, a, b, op, rs, illegal
    function automatic logic [18:0] ev(input logic [3:0] st, input logic req, input logic we,
                                       input logic adr, input logic irw, input logic pcw,
                                       input logic rw, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] rs, input logic ill);
        return {st, req, we, adr, irw, pcw, rw, a, b, op, rs, ill};
    endfunction

    function automatic logic [18:0] observed();
        return {state_dbg, mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, illegal};
    endfunction

    // One clock cycle: apply inputs, queue expectation, compare at negedge
    task automatic step(input string tag, input logic rdy, input logic br, input logic [18:0] e);
        logic [18:0] exp_v;
        mem_ready = rdy;
        br_taken  = br;
        sb_q.push_back(e);
        @(negedge clk);
        exp_v = sb_q.pop_front();
        check_eq(tag, 32'(observed()), 32'(exp_v));
        @(posedge clk);
        #1;
    endtask

    // Common cycle shapes
    task automatic fetch_ok(input string tag);
        step(tag, 1'b1, 1'b0, ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0));
    endtask

    task automatic decode(input string tag, input logic rdy);
        step(tag, rdy, 1'b0, ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));
    endtask

    task automatic aluwb(input string tag);
        step(tag, 1'b1, 1'b0, ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        opcode       = 7'b0010011;
        funct3       = 3'b000;
        funct7b5     = 1'b0;
        br_taken     = 1'b0;
        mem_ready    = 1'b0;
        #1;

        // Reset: all idle even with mem_ready asserted
        step("rst_idle", 1'b1, 1'b0, ev(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        check_eq("pc_init", pc_init, 32'h0000_1000);
        rst_n = 1'b1;

        // addi: FETCH (one wait), DECODE, EXECI, ALUWB
        opcode = 7'b0010011;
        step("addi_fwait", 1'b0, 1'b0, ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        fetch_ok("addi_f");
        decode("addi_d", 1'b1);
        step("addi_ex", 1'b1, 1'b0, ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 1'b0));
        aluwb("addi_wb");

        // add: EXECR
        opcode = 7'b0110011;
        fetch_ok("add_f");
        decode("add_d", 1'b0);
        step("add_ex", 1'b0, 1'b0, ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0));
        aluwb("add_wb");

        // lw with three wait cycles in MEMRD
        opcode = 7'b0000011;
        fetch_ok("lw_f");
        decode("lw_d", 1'b0);
        step("lw_adr", 1'b1, 1'b0, ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
        for (int i = 0; i < 3; i++)
            step("lw_rdwait", 1'b0, 1'b0, ev(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step("lw_rd", 1'b1, 1'b0, ev(4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step("lw_wb", 1'b1, 1'b0, ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0));

        // sw with one wait in MEMWR
        opcode = 7'b0100011;
        fetch_ok("sw_f");
        decode("sw_d", 1'b0);
        step("sw_adr", 1'b0, 1'b0, ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
        step("sw_wrwait", 1'b0, 1'b0, ev(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));
        step("sw_wr", 1'b1, 1'b0, ev(4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

        // beq taken, then not taken
        opcode = 7'b1100011;
        fetch_ok("beqt_f");
        decode("beqt_d", 1'b0);
        step("beqt_br", 1'b0, 1'b1, ev(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0));
        fetch_ok("beqn_f");
        decode("beqn_d", 1'b0);
        step("beqn_br", 1'b1, 1'b0, ev(4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0));

        // jal
        opcode = 7'b1101111;
        fetch_ok("jal_f");
        decode("jal_d", 1'b0);
        step("jal_ex", 1'b0, 1'b0, ev(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0));
        aluwb("jal_wb");

        // jalr x1,0(x2)
        opcode = 7'b1100111;
        fetch_ok("jalr_f");
        decode("jalr_d", 1'b0);
        step("jalr_ex", 1'b0, 1'b0, ev(4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0));
        step("jalr_wb", 1'b0, 1'b0, ev(4'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10, 2'b00, 2'b10, 1'b0));

        // lui, auipc
        opcode = 7'b0110111;
        fetch_ok("lui_f");
        decode("lui_d", 1'b0);
        step("lui_ex", 1'b0, 1'b0, ev(4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 1'b0));
        aluwb("lui_wb");
        opcode = 7'b0010111;
        fetch_ok("auipc_f");
        decode("auipc_d", 1'b0);
        step("auipc_ex", 1'b0, 1'b0, ev(4'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0));
        aluwb("auipc_wb");

        // Reset asserted mid-MEMRD: mem_req must drop without a clock edge
        opcode = 7'b0000011;
        fetch_ok("rlw_f");
        decode("rlw_d", 1'b0);
        step("rlw_adr", 1'b0, 1'b0, ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0));
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("rlw_rd_req", 32'(mem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rlw_req_drop", 32'(mem_req), 32'd0);
        check_eq("rlw_state", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rlw_after", 1'b0, 1'b0, ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

        // Illegal opcode: HALT absorbing, illegal sticky, no requests
        opcode = 7'b1111111;
        fetch_ok("ill_f");
        decode("ill_d", 1'b1);
        for (int i = 0; i < 3; i++)
            step("ill_halt", 1'b1, 1'b1, ev(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        opcode = 7'b0010011;
        step("ill_hold", 1'b1, 1'b0, ev(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1));
        rst_n = 1'b0;
        #1;
        check_eq("ill_clr", 32'(illegal), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("ill_restart", 1'b0, 1'b0, ev(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0));

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
